// File: rtl/tdm_demux_1x8.sv
// tdm_demux_1x8: serial TDM receiver steering samples into 8 slots and publishing whole frames
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid, in_data     serial sample lane (one sample per valid cycle)
//   in_sof                marks the accepted sample as slot 0 of a new frame
//   ch_strobe             one-hot: slot written on the last edge
//   slot                  slot the next accepted sample will occupy
//   out_bus               last complete frame, slot k at [k*WIDTH +: WIDTH]
//   out_valid, frame_err  single-cycle pulses: frame published / framing fault
module tdm_demux_1x8 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sof,
    output logic [7:0]         ch_strobe,
    output logic [2:0]         slot,
    output logic [8*WIDTH-1:0] out_bus,
    output logic               out_valid,
    output logic               frame_err
);
    typedef enum logic {HUNT, RUN} state_t;
    state_t               state_q, state_d;
    logic [2:0]           slot_q, slot_d;
    logic [7*WIDTH-1:0]   shadow_q, shadow_d;
    logic [8*WIDTH-1:0]   out_bus_q, out_bus_d;
    logic [7:0]           ch_strobe_q, ch_strobe_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_err_q, frame_err_d;
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        out_bus_d   = out_bus_q;
        ch_strobe_d = 8'h00;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                // SOF always restarts at slot 0; only an SOF landing mid-frame is a fault
                frame_err_d = (state_q == RUN) && (slot_q != 3'd0);
                shadow_d[0 +: WIDTH] = in_data;
                ch_strobe_d = 8'h01;
                slot_d      = 3'd1;
                state_d     = RUN;
            end else if (state_q == RUN) begin
                if (slot_q == 3'd0) begin
                    // frame boundary without SOF: lost alignment, resynchronise
                    frame_err_d = 1'b1;
                    state_d     = HUNT;
                end else begin
                    ch_strobe_d = 8'(1) << slot_q;
                    slot_d      = slot_q + 3'd1;
                    for (int k = 1; k < 7; k++)
                        if (slot_q == 3'(k)) shadow_d[k*WIDTH +: WIDTH] = in_data;
                    if (slot_q == 3'd7) begin
                        // slot 7 bypasses the shadow and completes the frame directly
                        out_bus_d   = {in_data, shadow_q};
                        out_valid_d = 1'b1;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= 3'd0;
            shadow_q    <= '0;
            out_bus_q   <= '0;
            ch_strobe_q <= 8'h00;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            out_bus_q   <= out_bus_d;
            ch_strobe_q <= ch_strobe_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end
    assign ch_strobe = ch_strobe_q;
    assign slot      = slot_q;
    assign out_bus   = out_bus_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_tdm_demux_1x8.sv
// tb_tdm_demux_1x8: directed self-checking bench for tdm_demux_1x8
module tb_tdm_demux_1x8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [0:0] in_data = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] ch_strobe;
    logic [2:0] slot;
    logic [7:0] out_bus;
    logic       out_valid;
    logic       frame_err;
    int checks = 0;
    int errors = 0;

    tdm_demux_1x8 #(.WIDTH(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
        .ch_strobe(ch_strobe), .slot(slot), .out_bus(out_bus),
        .out_valid(out_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic v, input logic sof, input logic d);
        @(negedge clk);
        rst = 1'b0; in_valid = v; in_sof = sof; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_data = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic [7:0] stb, input logic [2:0] sl,
                               input logic [7:0] bus, input logic ov, input logic fe);
        check({tag, ".strobe"}, 32'(ch_strobe), 32'(stb));
        check({tag, ".slot"},   32'(slot),      32'(sl));
        check({tag, ".bus"},    32'(out_bus),   32'(bus));
        check({tag, ".valid"},  32'(out_valid), 32'(ov));
        check({tag, ".err"},    32'(frame_err), 32'(fe));
    endtask

    task automatic send_frame(input string tag, input logic [7:0] d, input logic [7:0] prev,
                              input logic first_err);
        for (int k = 0; k < 8; k++) begin
            send(1'b1, k == 0, d[k]);
            expect_outs($sformatf("%s.s%0d", tag, k), 8'(1) << k, 3'((k + 1) % 8),
                        (k == 7) ? d : prev, k == 7, (k == 0) && first_err);
        end
    endtask

    initial begin
        // reset state
        do_reset();
        do_reset();
        expect_outs("rst", 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);

        // 1: single frame 1,0,1,1,0,0,1,0
        send_frame("t1", 8'h4D, 8'h00, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        expect_outs("t1.idle", 8'h00, 3'd0, 8'h4D, 1'b0, 1'b0);

        // 2: back-to-back frames, no gaps
        send_frame("t2a", 8'hA5, 8'h4D, 1'b0);
        send_frame("t2b", 8'h3C, 8'hA5, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        expect_outs("t2.idle", 8'h00, 3'd0, 8'h3C, 1'b0, 1'b0);

        // 3: non-SOF samples after reset are ignored
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, 1'b1);
            expect_outs($sformatf("t3.hunt%0d", i), 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
        end
        send_frame("t3", 8'h96, 8'h00, 1'b0);

        // 4: early SOF at slot 4
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        expect_outs("t4.pre", 8'h08, 3'd4, 8'h96, 1'b0, 1'b0);
        send_frame("t4", 8'h5A, 8'h96, 1'b1);

        // 5: missing SOF after slot 7 -> HUNT
        send(1'b1, 1'b0, 1'b1);
        expect_outs("t5.miss", 8'h00, 3'd0, 8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            send(1'b1, 1'b0, 1'b1);
            expect_outs($sformatf("t5.drop%0d", i), 8'h00, 3'd0, 8'h5A, 1'b0, 1'b0);
        end
        send_frame("t5", 8'hC3, 8'h5A, 1'b0);

        // 6a: gap mid-frame keeps slot and shadow (frame E7)
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b1, 1'b1);
            expect_outs($sformatf("t6a.gap%0d", i), 8'h00, 3'd4, 8'hC3, 1'b0, 1'b0);
        end
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        expect_outs("t6a.done", 8'h80, 3'd0, 8'hE7, 1'b1, 1'b0);

        // 6: gap then reset at slot 5
        send(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) send(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0, 1'b0);
            expect_outs($sformatf("t6.gap%0d", i), 8'h00, 3'd5, 8'hE7, 1'b0, 1'b0);
        end
        do_reset();
        expect_outs("t6.rst", 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        expect_outs("t6.hunt", 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1);
        expect_outs("t6.sof", 8'h01, 3'd1, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
